ws2812_rx_apb: RTL and testbench
================================

WS2812_RX_APB -- requirements
Module: ws2812_rx_apb

Interface
REQ-001 Parameters SHALL be: T_BIT_THRESH, 61, high-time in clocks at or above which a bit decodes as 1.
REQ-002 Parameters SHALL be: T_MIN_HIGH, 10, high-time below which a pulse is a glitch and is ignored.
REQ-003 Parameters SHALL be: T_MAX_HIGH, 110, high-time above which a pulse is a protocol error.
REQ-004 Parameters SHALL be: T_RESET_LOW, 5000, low-time in clocks that ends a frame.
REQ-005 Parameters SHALL be: FIFO_DEPTH, 8, decoded-word FIFO depth (power of 2).
REQ-006 Ports SHALL be: PCLK  in  1  clock; the only clock.
REQ-007 Ports SHALL be: PRESERN  in  1  reset, asynchronous, active-low.
REQ-008 Ports SHALL be: PSEL, PENABLE, PWRITE  in  1 each  APB3 control.
REQ-009 Ports SHALL be: PADDR  in  32  address (only PADDR[3:2] decoded); PWDATA  in  32  write data.
REQ-010 Ports SHALL be: PRDATA  out  32  read data; PREADY  out  1  tied 1; PSLVERR  out  1  tied 0.
REQ-011 Ports SHALL be: DIN  in  1  asynchronous single-wire pulse-width-coded serial input.
REQ-012 Ports SHALL be: IRQ  out  1  high while FIFO non-empty and CTRL.irq_en=1.

Function
REQ-013 DIN SHALL pass through a 2-flop synchronizer; all timing is measured on the synchronized signal.
REQ-014 The FSM SHALL have states WAIT_RST, LOW, HIGH.
REQ-015 WAIT_RST: count low clocks; reaching T_RESET_LOW -> LOW with bit count 0; any high resets the count and stays in WAIT_RST.
REQ-016 LOW: rising edge -> HIGH with high counter 1; low counter reaching T_RESET_LOW -> end of frame (REQ-021), stay in LOW.
REQ-017 HIGH: falling edge -> LOW, classify the pulse on that cycle; high counter exceeding T_MAX_HIGH -> set ERR sticky, discard partial word, -> WAIT_RST.
REQ-018 Classification: high < T_MIN_HIGH -> ignored, no bit; T_MIN_HIGH..T_BIT_THRESH-1 -> 0; T_BIT_THRESH..T_MAX_HIGH -> 1.
REQ-019 Bits SHALL shift MSB-first into a 24-bit shift register; the 24th bit pushes {8'h00, word} into the FIFO on the next clock and clears the bit count.
REQ-020 High and low counters SHALL saturate, never wrap.
REQ-021 End of frame with bit count 0 SHALL set FRAME sticky; with nonzero bit count it SHALL discard the partial word and set both FRAME and PARTIAL sticky.
REQ-022 Push to a full FIFO without a same-cycle pop SHALL drop the word and set OVF sticky; push and pop in the same cycle when full SHALL both succeed.
REQ-023 Register map (PADDR[3:2]): 0 DATA (RO, pop), 1 STATUS, 2 CTRL (RW), 3 reads 0.
REQ-024 STATUS SHALL be: [3:0] FIFO count (saturating display at 15), [4] empty, [5] full, [8] OVF, [9] ERR, [10] FRAME, [11] PARTIAL.
REQ-025 A write to STATUS SHALL clear each sticky bit whose PWDATA bit is 1 (W1C); a set event in the same cycle wins.
REQ-026 CTRL SHALL be: [0] enable, [1] irq_en, [2] flush (self-clearing, empties FIFO and returns FSM to WAIT_RST).
REQ-027 With enable=0 the FSM SHALL be held in WAIT_RST with counters 0; FIFO contents are retained.
REQ-028 PRDATA SHALL be combinational from PADDR while PSEL=1, else 0.
REQ-029 A DATA read (PSEL&PENABLE&!PWRITE) SHALL return the FIFO head and pop it on that edge; reading an empty FIFO returns 0 and does not pop.

Reset
REQ-030 On PRESERN low, SHALL asynchronously set: FSM WAIT_RST, counters 0, FIFO empty, stickies 0, CTRL=0, IRQ=0, synchronizer flops 0.
REQ-031 Deassertion SHALL be the only path out of reset; a frame in progress at reset is lost and decoding restarts with a fresh T_RESET_LOW low period.

Verification
REQ-032 Enable, 5000-clock low, 24 pulses encoding 0xA5C33C (81-clock high = 1, 41-clock high = 0, 125-clock period), 5000 low -> DATA reads 0x00A5C33C, STATUS.FRAME=1, PARTIAL=0.
REQ-033 Nine words sent without reads -> first 8 read back in order, 9th dropped, STATUS.OVF=1; W1C write 0x100 -> OVF=0.
REQ-034 12 bits then 5000-clock low -> FIFO empty, STATUS.FRAME=1, PARTIAL=1.
REQ-035 5-clock glitch between bits of a 24-bit word -> word decodes identical to the glitch-free case; 120-clock high -> ERR=1, nothing pushed.
REQ-036 PRESERN asserted mid-word with 3 words in FIFO -> FIFO empty, CTRL=0, IRQ=0 immediately; after release, decoding requires a new 5000-clock low.

Source files
------------

// File: rtl/ws2812_rx_apb.sv
`timescale 1ns/1ps
// Purpose: decodes a single-wire pulse-width-coded serial stream (WS2812 style) into 24-bit words,
//          buffers them in a FIFO and exposes DATA/STATUS/CTRL to an APB3 slave port, with a level IRQ.
// Latency: a word enters the FIFO 1 clock after its 24th falling edge, measured after the 2-flop DIN synchronizer.
// Backpressure: APB never stalls (PREADY=1); a word arriving at a full FIFO is dropped and OVF is flagged.
// Ports: PCLK/PRESERN clock and async active-low reset; PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR APB3;
//        DIN async serial input; IRQ high while the FIFO holds data and CTRL.irq_en is set.
module ws2812_rx_apb #(
    parameter int T_BIT_THRESH = 61,
    parameter int T_MIN_HIGH   = 10,
    parameter int T_MAX_HIGH   = 110,
    parameter int T_RESET_LOW  = 5000,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        DIN,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        WAIT_RST = 2'd0,
        LOW      = 2'd1,
        HIGH     = 2'd2
    } state_t;

    localparam int LW = $clog2(T_RESET_LOW + 1);
    localparam int HW = $clog2(T_MAX_HIGH + 2);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [LW-1:0] LOW_END = LW'(T_RESET_LOW);
    localparam logic [HW-1:0] H_MIN   = HW'(T_MIN_HIGH);
    localparam logic [HW-1:0] H_ONE   = HW'(T_BIT_THRESH);
    localparam logic [HW-1:0] H_MAX   = HW'(T_MAX_HIGH);
    localparam logic [CW-1:0] DEPTH   = CW'(FIFO_DEPTH);

    logic          din_meta;
    logic          din_sync;
    state_t        state_q;
    state_t        state_d;
    logic [LW-1:0] low_q;
    logic [LW-1:0] low_d;
    logic [HW-1:0] high_q;
    logic [HW-1:0] high_d;
    logic          bit_vld;
    logic          bit_val;
    logic          eof;
    logic          err_evt;
    logic [4:0]    bit_cnt;
    logic [23:0]   shreg;
    logic          push_pend;

    logic [23:0]   mem [FIFO_DEPTH];
    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic [CW-1:0] fifo_cnt;
    logic [31:0]   cnt_ext;
    logic [3:0]    cnt_disp;
    logic          empty;
    logic          full;
    logic          pop;
    logic          do_push;
    logic          ovf_set;

    logic          ctrl_en;
    logic          irq_en;
    logic          st_ovf;
    logic          st_err;
    logic          st_frame;
    logic          st_partial;
    logic [1:0]    addr;
    logic          apb_wr;
    logic          apb_rd;
    logic          wr_status;
    logic          flush;
    logic [31:0]   status;
    logic          unused;

    assign unused = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:12], PWDATA[7:3]};

    // DIN synchronizer
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            din_meta <= 1'b0;
            din_sync <= 1'b0;
        end else begin
            din_meta <= DIN;
            din_sync <= din_meta;
        end
    end

    // APB decode
    assign addr      = PADDR[3:2];
    assign apb_wr    = PSEL & PENABLE & PWRITE;
    assign apb_rd    = PSEL & PENABLE & ~PWRITE;
    assign wr_status = apb_wr && (addr == 2'd1);
    assign flush     = apb_wr && (addr == 2'd2) && PWDATA[2];
    assign pop       = apb_rd && (addr == 2'd0) && !empty;

    // Pulse FSM: next state, counters and per-cycle events.
    // Entering LOW from WAIT_RST keeps the low counter parked at LOW_END so an idle
    // line only produces an end-of-frame after at least one pulse has been seen.
    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        high_d  = high_q;
        bit_vld = 1'b0;
        bit_val = 1'b0;
        eof     = 1'b0;
        err_evt = 1'b0;
        case (state_q)
            WAIT_RST: begin
                if (din_sync) begin
                    low_d = '0;
                end else if (low_q >= LOW_END - 1'b1) begin
                    low_d   = LOW_END;
                    state_d = LOW;
                end else begin
                    low_d = low_q + 1'b1;
                end
            end
            LOW: begin
                if (din_sync) begin
                    state_d = HIGH;
                    high_d  = HW'(1);
                    low_d   = '0;
                end else if (low_q != LOW_END) begin
                    low_d = low_q + 1'b1;
                    eof   = (low_q == LOW_END - 1'b1);
                end
            end
            HIGH: begin
                if (!din_sync) begin
                    state_d = LOW;
                    low_d   = LW'(1);
                    high_d  = '0;
                    bit_vld = (high_q >= H_MIN);
                    bit_val = (high_q >= H_ONE);
                end else if (high_q >= H_MAX) begin
                    // this cycle would be high clock T_MAX_HIGH+1
                    state_d = WAIT_RST;
                    low_d   = '0;
                    high_d  = '0;
                    err_evt = 1'b1;
                end else begin
                    high_d = high_q + 1'b1;
                end
            end
            default: begin
                state_d = WAIT_RST;
                low_d   = '0;
                high_d  = '0;
            end
        endcase
        if (!ctrl_en || flush) begin
            state_d = WAIT_RST;
            low_d   = '0;
            high_d  = '0;
            bit_vld = 1'b0;
            eof     = 1'b0;
            err_evt = 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q   <= WAIT_RST;
            low_q     <= '0;
            high_q    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            push_pend <= 1'b0;
        end else begin
            state_q   <= state_d;
            low_q     <= low_d;
            high_q    <= high_d;
            push_pend <= 1'b0;
            if (flush || !ctrl_en || err_evt || eof) begin
                bit_cnt <= '0;
            end else if (bit_vld) begin
                shreg <= {shreg[22:0], bit_val};
                if (bit_cnt == 5'd23) begin
                    bit_cnt   <= '0;
                    push_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // FIFO; a pop frees the slot a same-cycle push into a full FIFO needs
    assign fifo_cnt = wptr - rptr;
    assign empty    = (fifo_cnt == '0);
    assign full     = (fifo_cnt == DEPTH);
    assign do_push  = push_pend && (!full || pop) && !flush;
    assign ovf_set  = push_pend && full && !pop && !flush;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (do_push) mem[wptr[AW-1:0]] <= shreg;
    end

    // Control and sticky status; a set event beats a same-cycle W1C
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            ctrl_en    <= 1'b0;
            irq_en     <= 1'b0;
            st_ovf     <= 1'b0;
            st_err     <= 1'b0;
            st_frame   <= 1'b0;
            st_partial <= 1'b0;
        end else begin
            if (apb_wr && (addr == 2'd2)) begin
                ctrl_en <= PWDATA[0];
                irq_en  <= PWDATA[1];
            end
            st_ovf     <= ovf_set | (st_ovf & ~(wr_status & PWDATA[8]));
            st_err     <= err_evt | (st_err & ~(wr_status & PWDATA[9]));
            st_frame   <= eof | (st_frame & ~(wr_status & PWDATA[10]));
            st_partial <= (eof && (bit_cnt != '0)) | (st_partial & ~(wr_status & PWDATA[11]));
        end
    end

    assign cnt_ext  = 32'(fifo_cnt);
    assign cnt_disp = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
    assign status   = {20'd0, st_partial, st_frame, st_err, st_ovf, 2'b00, full, empty, cnt_disp};

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (addr)
                2'd0:    PRDATA = empty ? 32'd0 : {8'h00, mem[rptr[AW-1:0]]};
                2'd1:    PRDATA = status;
                2'd2:    PRDATA = {30'd0, irq_en, ctrl_en};
                default: PRDATA = '0;
            endcase
        end
    end

    assign IRQ     = !empty && irq_en;
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

endmodule

// File: tb/tb_ws2812_rx_apb.sv
`timescale 1ns/1ps
module tb_ws2812_rx_apb;

    localparam int T_BIT_THRESH = 61;
    localparam int T_MIN_HIGH   = 10;
    localparam int T_MAX_HIGH   = 110;
    localparam int T_RESET_LOW  = 5000;
    localparam int FIFO_DEPTH   = 8;

    logic        PCLK = 1'b0;
    logic        PRESERN;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        DIN;
    logic        IRQ;

    int checks   = 0;
    int failures = 0;

    // Reference model: decoded words and flags derived from pulse widths
    logic [23:0] q[$];
    logic [23:0] m_word = '0;
    int          m_nbits = 0;
    bit          m_synced = 0, m_act = 0;
    bit          m_ovf = 0, m_err = 0, m_frame = 0, m_partial = 0;
    bit          m_en = 0, m_irq_en = 0;

    always #5 PCLK = ~PCLK;

    ws2812_rx_apb #(
        .T_BIT_THRESH(T_BIT_THRESH),
        .T_MIN_HIGH  (T_MIN_HIGH),
        .T_MAX_HIGH  (T_MAX_HIGH),
        .T_RESET_LOW (T_RESET_LOW),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .PCLK   (PCLK),
        .PRESERN(PRESERN),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR),
        .DIN    (DIN),
        .IRQ    (IRQ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] rd);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 rd = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic model_resync();
        m_synced = 0; m_act = 0; m_nbits = 0;
    endtask

    task automatic send_pulse(input int hi, input int lo);
        logic b;
        if (m_synced) begin
            if (hi > T_MAX_HIGH) begin
                m_err = 1; m_nbits = 0; m_synced = 0; m_act = 0;
            end else begin
                m_act = 1;
                if (hi >= T_MIN_HIGH) begin
                    b = (hi >= T_BIT_THRESH);
                    m_word = {m_word[22:0], b};
                    m_nbits++;
                    if (m_nbits == 24) begin
                        m_nbits = 0;
                        if (q.size() < FIFO_DEPTH) q.push_back(m_word);
                        else m_ovf = 1;
                    end
                end
            end
        end
        DIN = 1'b1;
        repeat (hi) @(negedge PCLK);
        DIN = 1'b0;
        repeat (lo) @(negedge PCLK);
    endtask

    task automatic send_bit_rand(input logic b);
        int hi;
        hi = b ? int'($urandom_range(T_BIT_THRESH, T_MAX_HIGH))
               : int'($urandom_range(T_MIN_HIGH, T_BIT_THRESH - 1));
        send_pulse(hi, int'($urandom_range(5, 15)));
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit_rand(w[i]);
    endtask

    task automatic frame_end();
        DIN = 1'b0;
        repeat (T_RESET_LOW + 20) @(negedge PCLK);
        if (!m_synced) begin
            m_synced = 1;
        end else if (m_act) begin
            m_frame = 1;
            if (m_nbits != 0) m_partial = 1;
            m_nbits = 0;
            m_act = 0;
        end
    endtask

    task automatic check_status(input string tag);
        logic [31:0] rd;
        logic [31:0] exp;
        int n;
        n = q.size();
        exp = '0;
        exp[3:0] = (n > 15) ? 4'hF : 4'(n);
        exp[4]  = (n == 0);
        exp[5]  = (n == FIFO_DEPTH);
        exp[8]  = m_ovf;
        exp[9]  = m_err;
        exp[10] = m_frame;
        exp[11] = m_partial;
        apb_read(32'h4, rd);
        check(tag, rd, exp);
    endtask

    task automatic read_data(input string tag, output logic [31:0] rd);
        logic [23:0] e;
        apb_read(32'h0, rd);
        if (q.size() != 0) e = q.pop_front();
        else e = '0;
        check(tag, rd, {8'h00, e});
    endtask

    task automatic check_irq(input string tag);
        check(tag, 32'(IRQ), 32'((q.size() != 0) && m_irq_en));
    endtask

    task automatic w1c(input logic [31:0] v);
        apb_write(32'h4, v);
        if (v[8])  m_ovf = 0;
        if (v[9])  m_err = 0;
        if (v[10]) m_frame = 0;
        if (v[11]) m_partial = 0;
    endtask

    task automatic ctrl_write(input logic [31:0] v);
        apb_write(32'h8, v);
        if (!v[0] || v[2] || !m_en) model_resync();
        if (v[2]) q.delete();
        m_en = v[0];
        m_irq_en = v[1];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [23:0] words[9];
        logic [23:0] w;
        logic [23:0] a5;
        logic [19:0] r20;

        PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; DIN = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst_irq", 32'(IRQ), 32'd0);
        PRESERN = 1'b1;
        @(negedge PCLK);
        check("pready", 32'(PREADY), 32'd1);
        check("pslverr", 32'(PSLVERR), 32'd0);
        check_status("rst_status");
        apb_read(32'h8, rd);
        check("rst_ctrl", rd, 32'd0);
        apb_read(32'hC, rd);
        check("addr3_zero", rd, 32'd0);
        read_data("rst_data_empty", rd);

        // Fixed-timing known word
        ctrl_write(32'h1);
        frame_end();
        a5 = 24'hA5C33C;
        for (int i = 23; i >= 0; i--) begin
            if (a5[i]) send_pulse(81, 44);
            else send_pulse(41, 84);
        end
        frame_end();
        check_status("a5_status");
        check_irq("a5_irq_off");
        ctrl_write(32'h3);
        check_irq("a5_irq_on");
        read_data("a5_data", rd);
        check("a5_word", rd, 32'h00A5C33C);
        check_irq("a5_irq_drained");

        // Nine random words, no reads: overflow
        w1c(32'hF00);
        for (int i = 0; i < 9; i++) begin
            words[i] = 24'($urandom());
            send_word(words[i]);
        end
        frame_end();
        check_status("ovf_status");
        check_irq("ovf_irq");
        for (int i = 0; i < 9; i++) begin
            read_data("ovf_data", rd);
            if (i < 8) check("ovf_order", rd, {8'h00, words[i]});
            else check("ovf_ninth_dropped", rd, 32'd0);
        end
        w1c(32'h100);
        check_status("ovf_w1c");

        // Partial word then frame end
        w1c(32'hF00);
        for (int i = 0; i < 12; i++) send_bit_rand(1'($urandom_range(0, 1)));
        frame_end();
        check_status("partial_status");

        // Boundary widths and glitches inside one word
        w1c(32'hF00);
        r20 = 20'($urandom());
        send_pulse(T_MIN_HIGH, 10);
        send_pulse(T_BIT_THRESH - 1, 10);
        send_pulse(T_BIT_THRESH, 10);
        send_pulse(T_MAX_HIGH, 10);
        send_pulse(5, 7);
        for (int i = 19; i >= 0; i--) begin
            send_bit_rand(r20[i]);
            if (i == 10) send_pulse(int'($urandom_range(1, T_MIN_HIGH - 1)), 6);
        end
        frame_end();
        check_status("bnd_status");
        read_data("bnd_data", rd);
        check("bnd_word", rd, {8'h00, 4'b0011, r20});

        // Over-long high mid-word
        w1c(32'hF00);
        for (int i = 0; i < 10; i++) send_bit_rand(1'($urandom_range(0, 1)));
        send_pulse(120, 30);
        frame_end();
        check_status("err_status");

        // Reset mid-word with three words buffered
        w1c(32'hF00);
        ctrl_write(32'h3);
        for (int i = 0; i < 3; i++) send_word(24'($urandom()));
        for (int i = 0; i < 10; i++) send_bit_rand(1'($urandom_range(0, 1)));
        check_status("prerst_status");
        check_irq("prerst_irq");
        PRESERN = 1'b0;
        #1 check("inrst_irq", 32'(IRQ), 32'd0);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h8;
        #1 check("inrst_ctrl", PRDATA, 32'd0);
        PADDR = 32'h4;
        #1 check("inrst_status", PRDATA, 32'h10);
        PSEL = 1'b0;
        q.delete();
        m_ovf = 0; m_err = 0; m_frame = 0; m_partial = 0; m_en = 0; m_irq_en = 0;
        model_resync();
        repeat (2) @(negedge PCLK);
        PRESERN = 1'b1;
        ctrl_write(32'h1);
        for (int i = 0; i < 8; i++) send_bit_rand(1'($urandom_range(0, 1)));
        frame_end();
        w = 24'($urandom());
        send_word(w);
        frame_end();
        check_status("postrst_status");
        read_data("postrst_data", rd);
        check("postrst_word", rd, {8'h00, w});

        // Flush
        send_word(24'($urandom()));
        check_status("preflush_status");
        ctrl_write(32'h5);
        check_status("flush_status");
        apb_read(32'h8, rd);
        check("flush_ctrl", rd, {30'd0, m_irq_en, m_en});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
